// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, mie bit positions and external-FSM states for irq_ctrl
package irq_ctrl_pkg;
  localparam logic [3:0] IRQ_IE = 4'h0;
  localparam logic [3:0] IRQ_EDGE = 4'h4;
  localparam logic [3:0] IRQ_PEND = 4'h8;
  localparam logic [3:0] IRQ_CLAIM = 4'hC;
  localparam int MEIE_BIT = 11;
  localparam int MTIE_BIT = 7;
  localparam int MSIE_BIT = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } ext_state_e;
endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// irq_sync_edge: per-line synchroniser; the extra last_q flop aligns rise with level timing
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign level = sync_q[SYNC_STAGES-1];
  assign rise = level & ~last_q;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt pending/arbitration with claim/complete, plus timer and software request masking
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int EXT_NUM = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [EXT_NUM-1:0] ext_irq_i,
  input  logic               tcmp_hit_i,
  input  logic               msip_i,
  input  logic [31:0]        mie_i,
  output logic               pex_trap_o,
  output logic               ptcmp_trap_o,
  output logic               psoft_trap_o,
  input  logic               pex_trap_rsp_i,
  input  logic               ptcmp_trap_rsp_i,
  input  logic               psoft_trap_rsp_i,
  input  logic               cfg_we_i,
  input  logic [3:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o
);
  logic [EXT_NUM-1:0] ie_q, edge_q, pend_q, pend_d, lvl, rise, cand, cur_oh, edge_chg, pend_clr;
  logic [31:0] pend32, ie32;
  logic [4:0] cur_id_q, win_id;
  logic win_vld, tmask_q, smask_q, serv;
  logic we_ie, we_edge, we_pend, we_claim, claim_take, claim_ok;
  logic unused_bits;
  ext_state_e state_q, state_d;
  genvar i;
  for (i = 0; i < EXT_NUM; i++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst_n(rst_n),
      .d(ext_irq_i[i]),
      .level(lvl[i]),
      .rise(rise[i])
    );
  end
  assign unused_bits = ^{cfg_addr_i[1:0], cfg_wdata_i, mie_i};
  assign we_ie = cfg_we_i && cfg_addr_i[3:2] == IRQ_IE[3:2];
  assign we_edge = cfg_we_i && cfg_addr_i[3:2] == IRQ_EDGE[3:2];
  assign we_pend = cfg_we_i && cfg_addr_i[3:2] == IRQ_PEND[3:2];
  assign we_claim = cfg_we_i && cfg_addr_i[3:2] == IRQ_CLAIM[3:2];
  assign serv = state_q == SERV;
  assign pend32 = 32'(pend_q);
  assign ie32 = 32'(ie_q);
  assign cur_oh = EXT_NUM'(1) << cur_id_q;
  assign cand = pend_q & ie_q & ~(serv ? cur_oh : '0);
  assign claim_take = state_q == REQ && pex_trap_rsp_i;
  assign claim_ok = we_claim && serv && cfg_wdata_i[4:0] == cur_id_q;
  // Edge bits: set beats clear; level bits track the line; a mode change drops the bit
  assign edge_chg = we_edge ? cfg_wdata_i[EXT_NUM-1:0] ^ edge_q : '0;
  assign pend_clr = (we_pend ? cfg_wdata_i[EXT_NUM-1:0] : '0) | (claim_take ? cur_oh : '0);
  assign pend_d = ~edge_chg & ((edge_q & (rise | (pend_q & ~pend_clr))) | (~edge_q & lvl));
  always_comb begin
    win_vld = |cand;
    win_id = '0;
    for (int k = EXT_NUM - 1; k >= 0; k--) if (cand[k]) win_id = 5'(k);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = win_vld && mie_i[MEIE_BIT] ? REQ : IDLE;
      REQ: state_d = pex_trap_rsp_i ? SERV :
                     !(pend32[cur_id_q] & ie32[cur_id_q]) || !mie_i[MEIE_BIT] ? IDLE : REQ;
      SERV: state_d = claim_ok ? IDLE : SERV;
      default: state_d = IDLE;
    endcase
  end
  always_comb pex_trap_o = state_q == REQ;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q <= '0;
      edge_q <= '0;
      pend_q <= '0;
      cur_id_q <= '0;
      tmask_q <= 1'b0;
      smask_q <= 1'b0;
    end else begin
      if (we_ie) ie_q <= cfg_wdata_i[EXT_NUM-1:0];
      if (we_edge) edge_q <= cfg_wdata_i[EXT_NUM-1:0];
      pend_q <= pend_d;
      if (state_q == IDLE && state_d == REQ) cur_id_q <= win_id;
      tmask_q <= ptcmp_trap_rsp_i | (tmask_q & tcmp_hit_i);
      smask_q <= psoft_trap_rsp_i | (smask_q & msip_i);
    end
  end
  assign ptcmp_trap_o = rst_n & tcmp_hit_i & mie_i[MTIE_BIT] & ~tmask_q;
  assign psoft_trap_o = rst_n & msip_i & mie_i[MSIE_BIT] & ~smask_q;
  always_comb
    cfg_rdata_o = cfg_addr_i[3:2] == IRQ_IE[3:2] ? ie32 :
                  cfg_addr_i[3:2] == IRQ_EDGE[3:2] ? 32'(edge_q) :
                  cfg_addr_i[3:2] == IRQ_PEND[3:2] ? pend32 :
                  {serv, 26'b0, serv ? cur_id_q : 5'd0};
endmodule
